// File: rtl/log2_sched.sv
// Round-robin front end for a single shared iterative log2 engine: grants one
// requester at a time, launches the engine, and returns the tagged result or error.
module log2_sched #(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic              eng_start,
  output logic [4:0]        eng_x,
  input  logic              eng_done,
  input  logic [10:0]       eng_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [10:0]       rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [9:0]      timer_q, timer_d;
  logic [4:0]      eng_x_q, eng_x_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [10:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic [4:0]      x_arr [NREQ];
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      x_arr[k] = req_x[5*k +: 5];
    end
  end

  // Scan starts at the pointer so the last-served requester is checked last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    timer_d     = timer_q;
    eng_x_d     = eng_x_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    eng_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld && !rst) begin
          req_ready[grant_idx] = 1'b1;
          rr_d     = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          rsp_id_d = grant_idx;
          if (x_arr[grant_idx] == 5'd0) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_RESP;
          end else begin
            eng_x_d = x_arr[grant_idx];
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 10'd1;
        if (eng_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = eng_result;
          state_d     = S_RESP;
        end else if (timer_q == 10'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      timer_q     <= '0;
      eng_x_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      eng_x_q     <= eng_x_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign eng_x     = eng_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_log2_sched.sv
// Directed bench for log2_sched: table of request/response vectors plus
// hand-written stall, reset-abort and timeout-boundary sequences.
module tb_log2_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req_valid = '0;
  logic [19:0] req_x = '0;
  logic [3:0]  req_ready;
  logic        eng_start;
  logic [4:0]  eng_x;
  logic        eng_done = 1'b0;
  logic [10:0] eng_result = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready = 1'b0;
  logic        busy;

  logic [3:0]  t_req_valid = '0;
  logic [19:0] t_req_x = '0;
  logic [3:0]  t_req_ready;
  logic        t_eng_start;
  logic [4:0]  t_eng_x;
  logic        t_eng_done = 1'b0;
  logic [10:0] t_eng_result = '0;
  logic        t_rsp_valid;
  logic [1:0]  t_rsp_id;
  logic [10:0] t_rsp_data;
  logic        t_rsp_err;
  logic        t_rsp_ready = 1'b0;
  logic        t_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int unsigned eng_lat = 1;
  logic [10:0] eng_val = '0;

  log2_sched #(.NREQ(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  log2_sched #(.NREQ(4), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_x(t_req_x), .req_ready(t_req_ready),
    .eng_start(t_eng_start), .eng_x(t_eng_x), .eng_done(t_eng_done), .eng_result(t_eng_result),
    .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
    .rsp_ready(t_rsp_ready), .busy(t_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  // Engine stand-in: done rises eng_lat rising edges after the launch cycle, for one cycle.
  initial forever begin
    @(negedge clk);
    if (eng_start === 1'b1) begin
      repeat (eng_lat) @(posedge clk);
      #1 eng_done = 1'b1; eng_result = eng_val;
      @(posedge clk);
      #1 eng_done = 1'b0;
    end
  end

  typedef struct {
    logic        rst_first;
    logic [3:0]  valid;
    logic [19:0] x;
    logic [10:0] result;
    int unsigned lat;
    logic [1:0]  exp_id;
    logic        exp_err;
    logic [10:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [19:0] pack(input logic [4:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [19:0] x,
                              input logic [10:0] res, input int unsigned lat,
                              input logic [1:0] id, input logic err, input logic [10:0] data);
    vec_t t;
    t.rst_first = r; t.valid = v; t.x = x; t.result = res; t.lat = lat;
    t.exp_id = id; t.exp_err = err; t.exp_data = data;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; t_req_valid = '0; rsp_ready = 1'b0; t_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (req_ready != '0) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    int lat_cnt;
    logic [19:0] xv;
    logic [4:0] xl;
    if (v.rst_first) do_reset();
    xv = v.x;
    xl = xv[5*v.exp_id +: 5];
    eng_lat = v.lat; eng_val = v.result;
    @(negedge clk); req_valid = v.valid; req_x = v.x; #1;
    wait_grant(seen);
    check("grant_seen", seen, 1);
    check("req_ready", req_ready, 1 << v.exp_id);
    seen = 1'b0; lat_cnt = 0;
    while (!seen && lat_cnt < 400) begin
      @(negedge clk); #1; lat_cnt++;
      if (lat_cnt == 1) req_valid = '0;
      if (eng_start) check("eng_x", eng_x, xl);
      if (rsp_valid) seen = 1'b1;
    end
    check("rsp_seen", seen, 1);
    check("latency", lat_cnt, v.exp_err ? 1 : v.lat + 2);
    check("rsp_id", rsp_id, v.exp_id);
    check("rsp_data", rsp_data, v.exp_data);
    check("rsp_err", rsp_err, v.exp_err);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  // d: offset (negedges after the launch sample) at which done is pulsed; <0 = never.
  task automatic t_run(input int d, input logic [10:0] res, input int exp_k, input logic exp_err);
    bit seen;
    int k;
    @(negedge clk); t_req_valid = 4'b0001; t_req_x = pack(5'd7, 5'd1, 5'd1, 5'd1); #1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (t_req_ready != '0) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("t_grant", t_req_ready, 4'b0001);
    @(negedge clk); #1;
    t_req_valid = '0;
    check("t_eng_start", t_eng_start, 1);
    check("t_eng_x", t_eng_x, 5'd7);
    t_eng_result = res;
    t_eng_done = (d == 0);
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk); #1; k++;
      if (t_rsp_valid) seen = 1'b1;
      else t_eng_done = (k == d);
    end
    t_eng_done = 1'b0;
    check("t_rsp_seen", seen, 1);
    check("t_rsp_cycles", k, exp_k);
    check("t_rsp_err", t_rsp_err, exp_err);
    check("t_rsp_data", t_rsp_data, exp_err ? 11'd0 : res);
    t_rsp_ready = 1'b1;
    @(negedge clk); #1;
    t_rsp_ready = 1'b0;
    check("t_idle", t_busy, 0);
  endtask

  initial begin
    bit seen;
    int c0;
    int spurious;

    tbl[0]  = mk(1, 4'b0001, pack(5'd8, 5'd0, 5'd0, 5'd0),    11'h180, 20, 2'd0, 0, 11'h180);
    tbl[1]  = mk(1, 4'b1111, pack(5'd1, 5'd2, 5'd3, 5'd4),    11'h0A1, 5,  2'd0, 0, 11'h0A1);
    tbl[2]  = mk(0, 4'b1111, pack(5'd5, 5'd6, 5'd7, 5'd9),    11'h0B2, 5,  2'd1, 0, 11'h0B2);
    tbl[3]  = mk(0, 4'b1111, pack(5'd10, 5'd11, 5'd12, 5'd13), 11'h0C3, 5, 2'd2, 0, 11'h0C3);
    tbl[4]  = mk(0, 4'b1111, pack(5'd14, 5'd15, 5'd16, 5'd18), 11'h0D4, 5, 2'd3, 0, 11'h0D4);
    tbl[5]  = mk(0, 4'b1111, pack(5'd19, 5'd20, 5'd21, 5'd22), 11'h0E5, 5, 2'd0, 0, 11'h0E5);
    tbl[6]  = mk(0, 4'b0001, pack(5'd31, 5'd0, 5'd0, 5'd0),   11'h111, 1,  2'd0, 0, 11'h111);
    tbl[7]  = mk(0, 4'b1100, pack(5'd0, 5'd0, 5'd23, 5'd24),  11'h222, 3,  2'd2, 0, 11'h222);
    tbl[8]  = mk(0, 4'b0110, pack(5'd0, 5'd25, 5'd26, 5'd0),  11'h333, 2,  2'd1, 0, 11'h333);
    tbl[9]  = mk(0, 4'b1000, pack(5'd0, 5'd0, 5'd0, 5'd0),    11'h444, 1,  2'd3, 1, 11'h000);
    tbl[10] = mk(0, 4'b0110, pack(5'd0, 5'd27, 5'd28, 5'd0),  11'h7FF, 7,  2'd1, 0, 11'h7FF);

    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_x", eng_x, 0);
    check("rst_t_busy", t_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Zero operand on id 2: immediate error response, engine untouched.
    do_reset();
    c0 = start_cnt;
    run_vec(mk(0, 4'b0100, pack(5'd5, 5'd5, 5'd0, 5'd5), 11'h123, 1, 2'd2, 1, 11'h000));
    repeat (3) @(negedge clk);
    check("zero_no_eng_start", start_cnt - c0, 0);

    // Response back-pressure: everything frozen while rsp_ready is low.
    do_reset();
    eng_lat = 4; eng_val = 11'h155;
    @(negedge clk); req_valid = 4'b0001; req_x = pack(5'd9, 5'd1, 5'd2, 5'd3); #1;
    wait_grant(seen);
    check("stall_grant", req_ready, 4'b0001);
    @(negedge clk); #1;
    req_valid = 4'b1111;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (rsp_valid) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("stall_rsp_seen", seen, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 11'h155);
      check("stall_id", rsp_id, 0);
      check("stall_err", rsp_err, 0);
      check("stall_req_ready", req_ready, 0);
      check("stall_eng_start", eng_start, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    check("stall_release", rsp_valid, 0);
    check("stall_next_grant", req_ready, 4'b0010);
    req_valid = '0;

    // Reset while waiting on the engine: abort silently, pointer back to 0.
    do_reset();
    eng_lat = 30; eng_val = 11'h3C3;
    @(negedge clk); req_valid = 4'b0100; req_x = pack(5'd1, 5'd1, 5'd12, 5'd1); #1;
    wait_grant(seen);
    check("abort_grant", req_ready, 4'b0100);
    @(negedge clk); #1;
    req_valid = '0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    check("abort_eng_x_before", eng_x, 5'd12);
    #2 rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_eng_start", eng_start, 0);
    check("abort_eng_x", eng_x, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_rsp_id", rsp_id, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_err", rsp_err, 0);
    @(negedge clk); rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) spurious++;
    end
    check("abort_late_done_ignored", spurious, 0);
    run_vec(mk(0, 4'b1111, pack(5'd3, 5'd4, 5'd5, 5'd6), 11'h2C1, 3, 2'd0, 0, 11'h2C1));

    // Timeout boundary on the TIMEOUT=16 instance.
    do_reset();
    t_run(-1, 11'h000, 17, 1);
    t_run(0,  11'h155, 17, 1);
    t_run(15, 11'h2AA, 16, 0);
    t_run(16, 11'h3AB, 17, 0);
    t_run(17, 11'h111, 17, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
